out_packer: RTL and testbench

Byte-stream to word-memory writer at the output end of the datapath. It collects 8-bit results from the compute stage and packs four consecutive bytes into one 32-bit word, first byte in bits [31:24]. Each word goes to the result memory through a request/acknowledge write port, at consecutive word addresses starting from a programmed base. It is the write-side counterpart of the 8-bit line buffer: it accepts bytes and emits the packed words that buffer consumes.

---
 rtl/out_packer.sv | 168 ++++++++++++++++
 tb/tb_out_packer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_packer.sv
// out_packer: packs a stream of result bytes into 32-bit words (first byte in
// [31:24]) and writes them through a req/ack port at consecutive word
// addresses starting from a programmed base.
// Optional feature macro: OUT_PACKER_PARTIAL_FLUSH_EN. When defined, a trailing
// partial word is written left-justified with zero fill. When undefined, a
// trailing partial word is dropped and the transfer ends without a write.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start, no transfer active
// COLLECT | accepting bytes into the holding register
// WRITE   | word presented on the memory port, waiting for mem_ack
// DONE    | transfer complete, done pulses for one cycle
module out_packer #(
    parameter int ADDR_W    = 16,
    parameter int ROW_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              row_done,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam int ROW_W = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROW_WORDS - 1);

`ifdef OUT_PACKER_PARTIAL_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              last_q, last_d;
    logic              row_done_q, row_done_d;

    logic accept;
    logic word_end;
    logic partial;
    logic ack_fire;

    assign accept   = (state_q == S_COLLECT) && in_valid;
    assign word_end = accept && ((cnt_q == 2'd3) || in_last);
    assign partial  = in_last && (cnt_q != 2'd3);
    assign ack_fire = (state_q == S_WRITE) && mem_ack;

    // State and datapath registers, all cleared by the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            hold_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            row_q      <= '0;
            last_q     <= 1'b0;
            row_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            last_q     <= last_d;
            row_done_q <= row_done_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COLLECT;
            end
            S_COLLECT: begin
                if (word_end) begin
                    // A dropped partial word skips the write entirely.
                    if (partial && !FLUSH_EN) state_d = S_DONE;
                    else                      state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ack) state_d = last_q ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte packing, address stepping and row tracking.
    always_comb begin
        addr_d     = addr_q;
        hold_d     = hold_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        row_d      = row_q;
        last_d     = last_q;
        row_done_d = 1'b0;

        if ((state_q == S_IDLE) && start) begin
            addr_d = base_addr;
            cnt_d  = '0;
            row_d  = '0;
            last_d = 1'b0;
        end

        if (accept) begin
            hold_d = {hold_q[23:0], in_data};
            cnt_d  = cnt_q + 2'd1;
            if (word_end) begin
                // Left-justify so a short final word keeps its first byte on top
                // and zero-fills the unused low bytes.
                wdata_d = hold_d << {2'd3 - cnt_q, 3'b000};
                last_d  = in_last;
                cnt_d   = '0;
            end
        end

        if (ack_fire) begin
            addr_d = addr_q + 1'b1;
            if (row_q == ROW_LAST) begin
                row_d      = '0;
                row_done_d = 1'b1;
            end else begin
                row_d = row_q + 1'b1;
            end
        end
    end

    // Outputs decoded from state and registered datapath.
    always_comb begin
        in_ready  = (state_q == S_COLLECT);
        mem_wr_en = (state_q == S_WRITE);
        busy      = (state_q == S_COLLECT) || (state_q == S_WRITE);
        done      = (state_q == S_DONE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        row_done  = row_done_q;
    end

endmodule

// File: tb/tb_out_packer.sv
// Testbench for out_packer: randomized transfers checked against a word-level
// model of the packing rules, plus directed back-pressure and reset cases.
module tb_out_packer;

    localparam int ADDR_W    = 16;
    localparam int ROW_WORDS = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic              row_done;
    logic              busy;
    logic              done;

    out_packer #(.ADDR_W(ADDR_W), .ROW_WORDS(ROW_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .row_done  (row_done),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int ack_mode = 0;   // 0: ack high, 1: random ack, 2: ack low
    int gap_max  = 0;
    int cyc = 0;
    int t_start = 0;
    int t_done = 0;

    logic [7:0]  tx[$];
    logic [47:0] exp_q[$];
    int          exp_rows;

    // Observed by the monitor only.
    logic [47:0] got_q[$];
    int row_cnt = 0;
    int done_cnt = 0;
    int stall_viol = 0;
    int ready_viol = 0;
    logic stall_prev = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory acknowledge driver, changed just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        case (ack_mode)
            0:       mem_ack = 1'b1;
            1:       mem_ack = 1'($urandom_range(0, 1));
            default: mem_ack = 1'b0;
        endcase
    end

    // Write-port monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (mem_wr_en !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_data))
                stall_viol++;
            if (mem_wr_en && in_ready) ready_viol++;
            if (mem_wr_en && mem_ack) got_q.push_back({mem_addr, mem_wdata});
            stall_prev = mem_wr_en && !mem_ack;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
            if (row_done) row_cnt++;
            if (done) done_cnt++;
        end
    end

    // Expected writes: every complete group of 4 bytes forms one word at
    // base + group index; a trailing partial group is only written when the
    // flush feature is built in.
    task automatic build_expected(input logic [ADDR_W-1:0] base);
        int nw;
        logic [31:0] d;
        logic [ADDR_W-1:0] a;
        exp_q.delete();
        nw = tx.size() / 4;
        for (int w = 0; w < nw; w++) begin
            d = {tx[4*w], tx[4*w+1], tx[4*w+2], tx[4*w+3]};
            a = base + ADDR_W'(w);
            exp_q.push_back({a, d});
        end
`ifdef OUT_PACKER_PARTIAL_FLUSH_EN
        begin
            int rem;
            rem = tx.size() % 4;
            if (rem > 0) begin
                d = 32'h0;
                for (int j = 0; j < rem; j++) d = d | (32'(tx[4*nw+j]) << (24 - 8*j));
                a = base + ADDR_W'(nw);
                exp_q.push_back({a, d});
            end
        end
`endif
        exp_rows = exp_q.size() / ROW_WORDS;
    endtask

    task automatic xfer_begin(input logic [ADDR_W-1:0] base);
        @(negedge clk);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        base_addr = ADDR_W'($urandom);
        t_start = cyc;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %0b exp 1", busy);
        end
    endtask

    task automatic send_all(input bit inject);
        foreach (tx[i]) begin
            int g;
            int w;
            bit acc;
            bit rdy;
            g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            repeat (g) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = tx[i];
            in_last  = (i == tx.size() - 1);
            if (inject && !in_last && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                base_addr = ADDR_W'($urandom);
            end
            acc = 1'b0;
            w = 0;
            while (!acc && w < 200) begin
                rdy = in_ready;
                @(posedge clk);
                acc = rdy;
                @(negedge clk);
                start = 1'b0;
                w++;
            end
            checks++;
            if (!acc) begin
                errors++;
                $display("FAIL byte_accept byte %0d got timeout exp accepted", i);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Full transfer scenario: start, stream tx, wait for done, compare writes.
    task automatic run_transfer(input logic [ADDR_W-1:0] base, input bit inject, input int exp_cyc);
        int g0, r0, d0, s0, n;
        g0 = got_q.size();
        r0 = row_cnt;
        d0 = done_cnt;
        s0 = stall_viol + ready_viol;
        build_expected(base);
        xfer_begin(base);
        send_all(inject);
        n = 0;
        while (done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        t_done = cyc;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_seen got %0b exp 1", done);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_with_done got %0b exp 0", busy);
        end
        if (exp_cyc > 0) begin
            checks++;
            if (t_done - t_start != exp_cyc) begin
                errors++;
                $display("FAIL xfer_cycles got %0d exp %0d", t_done - t_start, exp_cyc);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done got busy=%0b in_ready=%0b exp 0 0", busy, in_ready);
        end
        @(negedge clk);
        checks++;
        if (got_q.size() - g0 != exp_q.size()) begin
            errors++;
            $display("FAIL write_count got %0d exp %0d", got_q.size() - g0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (g0 + i < got_q.size()) begin
                checks++;
                if (got_q[g0+i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL write_%0d got addr=%h data=%h exp addr=%h data=%h", i,
                             got_q[g0+i][47:32], got_q[g0+i][31:0], exp_q[i][47:32], exp_q[i][31:0]);
                end
            end
        end
        checks++;
        if (row_cnt - r0 != exp_rows) begin
            errors++;
            $display("FAIL row_done_count got %0d exp %0d", row_cnt - r0, exp_rows);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL done_count got %0d exp 1", done_cnt - d0);
        end
        checks++;
        if (stall_viol + ready_viol != s0) begin
            errors++;
            $display("FAIL port_protocol got %0d violations exp 0", stall_viol + ready_viol - s0);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_wr_en, row_done, busy, done} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b wr=%0b addr=%h data=%h row=%0b busy=%0b done=%0b exp all 0",
                     in_ready, mem_wr_en, mem_addr, mem_wdata, row_done, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got rdy=%0b busy=%0b wr=%0b exp 0 0 0", in_ready, busy, mem_wr_en);
        end
    endtask

    task automatic test_basic;
        ack_mode = 0;
        gap_max  = 0;
        tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_transfer(16'h0010, 1'b0, 10);
    endtask

    task automatic test_row;
        ack_mode = 0;
        gap_max  = 0;
        tx.delete();
        for (int i = 0; i < 16; i++) tx.push_back(8'(i));
        run_transfer(16'h0123, 1'b0, 20);
    endtask

    task automatic test_backpressure;
        ack_mode = 2;
        gap_max  = 0;
        tx.delete();
        for (int i = 0; i < 4; i++) tx.push_back(8'($urandom));
        fork
            run_transfer(16'h0200, 1'b0, 0);
            begin
                int n;
                logic [ADDR_W-1:0] a_ref;
                logic [31:0] d_ref;
                n = 0;
                while (mem_wr_en !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                a_ref = mem_addr;
                d_ref = mem_wdata;
                checks++;
                if (d_ref !== {tx[0], tx[1], tx[2], tx[3]} || a_ref !== 16'h0200) begin
                    errors++;
                    $display("FAIL stall_word got addr=%h data=%h exp addr=0200 data=%h",
                             a_ref, d_ref, {tx[0], tx[1], tx[2], tx[3]});
                end
                repeat (7) begin
                    @(negedge clk);
                    checks++;
                    if (mem_wr_en !== 1'b1 || mem_addr !== a_ref || mem_wdata !== d_ref || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_hold got wr=%0b addr=%h data=%h rdy=%0b exp 1 %h %h 0",
                                 mem_wr_en, mem_addr, mem_wdata, in_ready, a_ref, d_ref);
                    end
                end
                ack_mode = 0;
            end
        join
    endtask

    task automatic test_wrap;
        ack_mode = 1;
        gap_max  = 1;
        tx.delete();
        for (int i = 0; i < 8; i++) tx.push_back(8'($urandom));
        run_transfer(16'hFFFF, 1'b0, 0);
    endtask

    task automatic test_partial;
        ack_mode = 0;
        gap_max  = 0;
        tx = '{8'hAA, 8'hBB};
        run_transfer(16'h0500, 1'b0, 0);
    endtask

    task automatic test_reset_mid;
        int n, g_before;
        ack_mode = 2;
        gap_max  = 0;
        tx = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        xfer_begin(16'h0300);
        send_all(1'b0);
        n = 0;
        while (mem_wr_en !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL pending_write got %0b exp 1", mem_wr_en);
        end
        rst = 1'b1;
        #1;
        g_before = got_q.size();
        checks++;
        if ({in_ready, mem_wr_en, row_done, busy, done} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy=%0b wr=%0b addr=%h data=%h row=%0b busy=%0b done=%0b exp all 0",
                     in_ready, mem_wr_en, mem_addr, mem_wdata, row_done, busy, done);
        end
        ack_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_transfer(16'h0040, 1'b0, 0);
        checks++;
        if (got_q.size() - g_before != 1) begin
            errors++;
            $display("FAIL writes_after_reset got %0d exp 1", got_q.size() - g_before);
        end
    endtask

    task automatic test_random;
        ack_mode = 1;
        gap_max  = 2;
        for (int t = 0; t < 8; t++) begin
            int len;
            len = $urandom_range(1, 20);
            tx.delete();
            for (int i = 0; i < len; i++) tx.push_back(8'($urandom));
            run_transfer(ADDR_W'($urandom), 1'b1, 0);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_row;
        test_backpressure;
        test_wrap;
        test_partial;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
